// File: rtl/store_buffer.sv
// Posted-write store buffer: in-order drain to data memory over req/ack,
// with combinational youngest-match forwarding to MEM-stage loads.
module store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   st_valid,
  input  logic [ADDR_W-1:0]      st_addr,
  input  logic [DATA_W-1:0]      st_data,
  output logic                   st_stall,
  input  logic                   ld_valid,
  input  logic [ADDR_W-1:0]      ld_addr,
  output logic                   ld_hit,
  output logic [DATA_W-1:0]      ld_data,
  output logic                   mem_req,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic                   mem_ack,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] REQ  = 1'b1;

  logic [ADDR_W-1:0] addrMem [DEPTH];
  logic [DATA_W-1:0] dataMem [DEPTH];

  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countNext;
  logic [0:0]       state;
  logic [0:0]       stateNext;
  logic             push;
  logic             pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = st_valid & ~full;
  assign st_stall = st_valid & full;
  assign pop      = (state == REQ) & mem_ack;

  assign mem_req   = (state == REQ);
  assign mem_addr  = addrMem[rdPtr];
  assign mem_wdata = dataMem[rdPtr];

  assign countNext = count + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (!empty) stateNext = REQ;
      REQ:  if (mem_ack && countNext == '0) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      state <= IDLE;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      count <= countNext;
      state <= stateNext;
    end
  end

  // Entry storage carries no reset; validity is tracked by rdPtr/count only.
  always_ff @(posedge clk) begin
    if (push) begin
      addrMem[wrPtr] <= st_addr;
      dataMem[wrPtr] <= st_data;
    end
  end

  // Walk entries oldest to youngest so the last match seen is the youngest.
  logic [PTR_W-1:0] idx;
  always_comb begin
    ld_hit  = 1'b0;
    ld_data = '0;
    idx     = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PTR_W'(k);
      if (ld_valid && (CNT_W'(k) < count) &&
          (addrMem[idx][ADDR_W-1:2] == ld_addr[ADDR_W-1:2])) begin
        ld_hit  = 1'b1;
        ld_data = dataMem[idx];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH=4, 32-bit addr/data).
module tb_store_buffer;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        st_stall;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic        ld_hit;
  logic [31:0] ld_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic        full;
  logic        empty;
  logic [2:0]  count;

  int nVec = 0;
  int nErr = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_stall(st_stall),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .full(full), .empty(empty), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushOne(input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1; st_addr = a; st_data = d;
    step();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAA0001;
    step(); step();
    nVec++; if (count !== 3'd0) begin nErr++; $display("FAIL rst_count got %0d want 0", count); end
    nVec++; if (empty !== 1'b1) begin nErr++; $display("FAIL rst_empty got %b want 1", empty); end
    nVec++; if (mem_req !== 1'b0) begin nErr++; $display("FAIL rst_memreq got %b want 0", mem_req); end
    nVec++; if (full !== 1'b0 || st_stall !== 1'b0) begin nErr++; $display("FAIL rst_full_stall got %b%b want 00", full, st_stall); end
    reset = 1'b1;
    step();
    st_valid = 1'b0;
    nVec++; if (count !== 3'd1) begin nErr++; $display("FAIL first_push_count got %0d want 1", count); end
    nVec++; if (mem_req !== 1'b0) begin nErr++; $display("FAIL first_push_req_early got %b want 0", mem_req); end
    step();
    nVec++; if (mem_req !== 1'b1) begin nErr++; $display("FAIL first_req got %b want 1", mem_req); end
    nVec++; if (mem_addr !== 32'h10 || mem_wdata !== 32'hAAAA0001) begin nErr++; $display("FAIL first_req_data got %h/%h want 00000010/aaaa0001", mem_addr, mem_wdata); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    nVec++; if (empty !== 1'b1 || mem_req !== 1'b0) begin nErr++; $display("FAIL first_drain got empty=%b req=%b want 1 0", empty, mem_req); end
  endtask

  task automatic test_fill_stall();
    logic [31:0] expA [4] = '{32'h04, 32'h08, 32'h0C, 32'h10};
    for (int i = 0; i < 4; i++) pushOne(32'(i * 4), 32'hD000_0000 + 32'(i));
    nVec++; if (full !== 1'b1 || count !== 3'd4) begin nErr++; $display("FAIL fill got full=%b count=%0d want 1 4", full, count); end
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hD000_0004;
    #1;
    nVec++; if (st_stall !== 1'b1) begin nErr++; $display("FAIL stall got %b want 1", st_stall); end
    step();
    nVec++; if (count !== 3'd4) begin nErr++; $display("FAIL stall_count got %0d want 4", count); end
    mem_ack = 1'b1;
    #1;
    nVec++; if (st_stall !== 1'b1) begin nErr++; $display("FAIL stall_with_ack got %b want 1", st_stall); end
    step();
    mem_ack = 1'b0;
    nVec++; if (count !== 3'd3 || st_stall !== 1'b0) begin nErr++; $display("FAIL pop_while_full got count=%0d stall=%b want 3 0", count, st_stall); end
    step();
    st_valid = 1'b0;
    nVec++; if (count !== 3'd4) begin nErr++; $display("FAIL held_store_accepted got %0d want 4", count); end
    mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nVec++; if (mem_req !== 1'b1 || mem_addr !== expA[i]) begin nErr++; $display("FAIL fill_drain%0d got req=%b addr=%h want 1 %h", i, mem_req, mem_addr, expA[i]); end
      step();
    end
    mem_ack = 1'b0;
    nVec++; if (empty !== 1'b1 || mem_req !== 1'b0) begin nErr++; $display("FAIL fill_drain_end got empty=%b req=%b want 1 0", empty, mem_req); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expA [3] = '{32'h00, 32'h04, 32'h08};
    logic [31:0] expD [3] = '{32'hB0, 32'hB1, 32'hB2};
    for (int i = 0; i < 3; i++) pushOne(expA[i], expD[i]);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nVec++; if (mem_req !== 1'b1 || mem_addr !== expA[i] || mem_wdata !== expD[i]) begin
        nErr++; $display("FAIL b2b%0d got req=%b %h/%h want 1 %h/%h", i, mem_req, mem_addr, mem_wdata, expA[i], expD[i]);
      end
      step();
    end
    mem_ack = 1'b0;
    nVec++; if (mem_req !== 1'b0 || empty !== 1'b1) begin nErr++; $display("FAIL b2b_end got req=%b empty=%b want 0 1", mem_req, empty); end
  endtask

  task automatic test_forward();
    pushOne(32'h20, 32'h1);
    pushOne(32'h24, 32'h2);
    pushOne(32'h20, 32'h3);
    ld_valid = 1'b1; ld_addr = 32'h22;
    #1;
    nVec++; if (ld_hit !== 1'b1 || ld_data !== 32'h3) begin nErr++; $display("FAIL fwd_youngest got %b/%h want 1/3", ld_hit, ld_data); end
    ld_addr = 32'h28;
    #1;
    nVec++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin nErr++; $display("FAIL fwd_miss got %b/%h want 0/0", ld_hit, ld_data); end
    ld_addr = 32'h27;
    #1;
    nVec++; if (ld_hit !== 1'b1 || ld_data !== 32'h2) begin nErr++; $display("FAIL fwd_mid got %b/%h want 1/2", ld_hit, ld_data); end
    ld_valid = 1'b0; ld_addr = 32'h20;
    #1;
    nVec++; if (ld_hit !== 1'b0 || ld_data !== 32'h0) begin nErr++; $display("FAIL fwd_novalid got %b/%h want 0/0", ld_hit, ld_data); end
    mem_ack = 1'b1;
    step(); step(); step();
    mem_ack = 1'b0;
    ld_valid = 1'b1;
    #1;
    nVec++; if (ld_hit !== 1'b0 || empty !== 1'b1) begin nErr++; $display("FAIL fwd_empty got hit=%b empty=%b want 0 1", ld_hit, empty); end
    ld_valid = 1'b0;
  endtask

  task automatic test_push_pop();
    pushOne(32'h40, 32'h11);
    pushOne(32'h44, 32'h22);
    st_valid = 1'b1; st_addr = 32'h48; st_data = 32'h33;
    mem_ack = 1'b1;
    ld_valid = 1'b1; ld_addr = 32'h40;
    #1;
    nVec++; if (mem_req !== 1'b1 || ld_hit !== 1'b1 || ld_data !== 32'h11) begin nErr++; $display("FAIL fwd_head got req=%b hit=%b data=%h want 1 1 11", mem_req, ld_hit, ld_data); end
    ld_addr = 32'h48;
    #1;
    nVec++; if (ld_hit !== 1'b0) begin nErr++; $display("FAIL fwd_same_cycle_enq got %b want 0", ld_hit); end
    step();
    st_valid = 1'b0; ld_valid = 1'b0;
    nVec++; if (count !== 3'd2 || mem_addr !== 32'h44) begin nErr++; $display("FAIL pushpop got count=%0d addr=%h want 2 44", count, mem_addr); end
    step();
    nVec++; if (mem_addr !== 32'h48 || mem_wdata !== 32'h33 || count !== 3'd1) begin nErr++; $display("FAIL pushpop_order got %h/%h count=%0d want 48/33 1", mem_addr, mem_wdata, count); end
    step();
    mem_ack = 1'b0;
    nVec++; if (empty !== 1'b1 || mem_req !== 1'b0) begin nErr++; $display("FAIL pushpop_end got empty=%b req=%b want 1 0", empty, mem_req); end
  endtask

  task automatic test_async_reset();
    pushOne(32'h50, 32'h55);
    pushOne(32'h54, 32'h66);
    nVec++; if (mem_req !== 1'b1 || count !== 3'd2) begin nErr++; $display("FAIL pre_reset got req=%b count=%0d want 1 2", mem_req, count); end
    #2 reset = 1'b0;
    #1;
    nVec++; if (mem_req !== 1'b0 || count !== 3'd0 || empty !== 1'b1) begin nErr++; $display("FAIL async_reset got req=%b count=%0d empty=%b want 0 0 1", mem_req, count, empty); end
    #1 reset = 1'b1;
    mem_ack = 1'b1;
    step(); step();
    mem_ack = 1'b0;
    nVec++; if (count !== 3'd0 || mem_req !== 1'b0) begin nErr++; $display("FAIL stray_ack got count=%0d req=%b want 0 0", count, mem_req); end
  endtask

  initial begin
    reset = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
    ld_valid = 1'b0; ld_addr = '0; mem_ack = 1'b0;
    test_reset();
    test_fill_stall();
    test_back_to_back();
    test_forward();
    test_push_pop();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
